mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, using a start/busy/done handshake. The controller stalls in a wait state until `done` is asserted. It also services MTHI/MTLO writes. HI/LO are read combinationally for MFHI/MFLO. The unit is the datapath's only source of HI/LO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be ≥ 4.
- `SIGNED_EN`, default 1: enables signed ops. When 0, `op[0]` is ignored and every op is unsigned.

- `clk`  in  1  clock. Everything is rising-edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `start`  in  1  launch request. Sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  rs operand (multiplicand/dividend).
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `hilo_wr`  in  1  MTHI/MTLO write strobe.
- `hilo_sel`  in  1  write target: 0 = LO, 1 = HI.
- `hilo_wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse. HI/LO hold the new result.
- `div_by_zero`  out  1  flag for the last completed op. Valid from `done` until the next `done`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE → RUN → FIX → IDLE.
  - IDLE with `start`=1 → RUN. `a`, `b`, `op` are captured at this edge; later operand changes have no effect.
  - RUN lasts exactly WIDTH cycles; a bit counter runs from 0 to WIDTH-1.
  - FIX: one cycle. Applies the sign correction, writes HI/LO, registers `done`, returns to IDLE.
- Signed ops: magnitudes are taken at capture. Result sign is corrected in FIX.
- Multiply:
  - shift-add on magnitudes; {hi,lo} = full 2·WIDTH-bit product.
  - Signed product is the two's complement of the magnitude product when the operand signs differ.
- Divide (restoring): lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Divisor 0: lo = all ones, hi = captured `a`, `div_by_zero` = 1. Latency is unchanged.
  - DIV most-negative / −1: lo = most-negative, hi = 0. No flag.
- `div_by_zero` is cleared on every non-div-by-zero completion.
- `hilo_wr` in IDLE: the selected register takes `hilo_wdata` at the next edge.
  - `hilo_wr` while busy is dropped.
  - `hilo_wr` and `start` in the same IDLE cycle: the write is applied, then overwritten by the op result in FIX.
- `start` while busy is ignored, not queued.
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; state IDLE.
- Reset mid-operation aborts the op. No `done` is produced.

## Timing
- Start accepted at edge E0.
- `busy` is 1 from after E0 through the FIX cycle: WIDTH+1 cycles.
- `hi`/`lo` update and `done`=1 after edge E0+WIDTH+1. `busy` is 0 in that same cycle.
- A `start` in the `done` cycle is accepted, giving back-to-back ops with a period of WIDTH+2 cycles.
- `done` is high for exactly one cycle.
- `hi`/`lo` never show intermediate values; internal accumulators are separate registers.
- MFHI/MFLO reads are combinational from `hi`/`lo`, zero latency.

## Structure
- Shared package `mips_muldiv_pkg`:
  - op codes `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`;
  - state encoding `ST_IDLE`/`ST_RUN`/`ST_FIX`;
  - the `HILO_SEL_LO`/`HILO_SEL_HI` constants.
- Single module. The counter is sized `$clog2(WIDTH)`.
- Internal registers: 2·WIDTH-bit product/remainder accumulator, WIDTH-bit operand register, sign flags.
- No sub-module needed. Magnitude/negate helpers are functions in the package.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → hi=0xFFFFFFFE, lo=0x00000001. `done` exactly 33 edges after the start edge; `busy` high 33 cycles.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 → lo=3, hi=1. DIV 0x80000000 / −1 → lo=0x80000000, hi=0, `div_by_zero`=0.
- DIV 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234, `div_by_zero`=1 with `done`. The next DIVU 9/3 clears the flag: lo=3, hi=0.
- MTHI 0xDEADBEEF in IDLE → hi=0xDEADBEEF the next cycle.
  - `hilo_wr` and a second `start` during RUN are both ignored; HI/LO change only at `done`.
  - A `start` in the `done` cycle produces a second `done` 33 edges later.
- `rst` low mid-RUN → after the next edge: `busy`=0, `hi`=`lo`=0, no `done`. A following MULTU 6×7 → lo=42, hi=0.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states,
// HI/LO write-select constants and the conditional-negate helper.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  // Widest value the helper handles: a full 2*WIDTH product for WIDTH <= 64.
  localparam int EXT_W = 128;

  // Two's complement negate when neg is set; callers size-cast the result back
  // down, which is exact because negation modulo 2^n only depends on low bits.
  function automatic logic [EXT_W-1:0] cond_neg(input logic [EXT_W-1:0] v, input logic neg);
    logic [EXT_W-1:0] r;
    if (neg) begin
      r = ~v + {{(EXT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit (one bit per cycle) owning the HI/LO
// architectural registers; HI/LO only change on MTHI/MTLO or at op completion.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_wr,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW       = $clog2(WIDTH);
  localparam int            AW       = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn_op_s, is_div_op_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, quo_s, rem_s;
  logic [WIDTH:0]   mul_sum_s, div_trial_s, div_diff_s;
  logic [AW-1:0]    mul_step_s, div_step_s, prod_s;

  assign sgn_op_s    = SIGNED_EN & op[0];
  assign is_div_op_s = (op == OP_DIVU) || (op == OP_DIV);
  assign mag_a_s     = WIDTH'(cond_neg(EXT_W'(a), sgn_op_s & a[WIDTH-1]));
  assign mag_b_s     = WIDTH'(cond_neg(EXT_W'(b), sgn_op_s & b[WIDTH-1]));

  // Shift-add: multiplier sits in the low half and is consumed from bit 0.
  assign mul_sum_s  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AW-1:1]};

  // Restoring divide: the trial remainder needs one extra bit after the shift.
  assign div_trial_s = acc_q[AW-1:WIDTH-1];
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};
  assign div_step_s  = div_diff_s[WIDTH] ? {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_s = AW'(cond_neg(EXT_W'(acc_q), neg_res_q));
  assign quo_s  = WIDTH'(cond_neg(EXT_W'(acc_q[WIDTH-1:0]), neg_res_q));
  assign rem_s  = WIDTH'(cond_neg(EXT_W'(acc_q[AW-1:WIDTH]), neg_rem_q));

  // Next-state and datapath update for IDLE/RUN/FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hilo_wr) begin
          if (hilo_sel == HILO_SEL_HI) begin
            hi_d = hilo_wdata;
          end else begin
            lo_d = hilo_wdata;
          end
        end else begin
          hi_d = hi_q;
        end
        if (start) begin
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = is_div_op_s;
          neg_res_d  = sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = sgn_op_s & a[WIDTH-1];
          dbz_pend_d = is_div_op_s && (b == {WIDTH{1'b0}});
          if (is_div_op_s) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a_s};
            opnd_d = mag_b_s;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b_s};
            opnd_d = mag_a_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = is_div_q ? div_step_s : mul_step_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d  = dbz_pend_q ? {WIDTH{1'b1}} : quo_s;
          hi_d  = rem_s;
          dbz_d = dbz_pend_q;
        end else begin
          {hi_d, lo_d} = prod_s;
          dbz_d        = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit at WIDTH=32.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hilo_wr;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat, bcnt, ndone;

  mips_muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hilo_wr    (hilo_wr),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
  endtask

  // Counts negedges until done, bounded; busy samples are counted while waiting.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
    int l, bc;
    launch(o, x, y);
    wait_done(l, bc);
    check_eq({tag, "_lat"}, 64'(l), 64'd33);
    check_eq({tag, "_hi"}, 64'(hi), 64'(ehi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(elo));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    hilo_wr = 1'b0; hilo_sel = 1'b0; hilo_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // MULTU all-ones squared, with latency and busy-window checks.
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bcnt);
    check_eq("multu_lat", 64'(lat), 64'd33);
    check_eq("multu_busy_cycles", 64'(bcnt), 64'd33);
    check_eq("multu_busy_at_done", 64'(busy), 64'd0);
    check_eq("multu_hi", 64'(hi), 64'hFFFFFFFE);
    check_eq("multu_lo", 64'(lo), 64'h00000001);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'd0);

    op_check("mult_neg3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    op_check("mult_minxmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    op_check("div_neg7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op_check("divu_7d2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    op_check("div_mindm1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    op_check("div_by0", 2'b11, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    op_check("divu_9d3", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    // MTHI then MTLO in IDLE.
    hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check_eq("mthi_lo_kept", 64'(lo), 64'd3);
    hilo_sel = 1'b0; hilo_wdata = 32'h0BADF00D;
    @(negedge clk);
    hilo_wr = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'h0BADF00D);
    check_eq("mtlo_hi_kept", 64'(hi), 64'hDEADBEEF);

    // hilo_wr and a second start during RUN are both dropped.
    launch(2'b00, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    hilo_wr = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h55;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd5;
    @(negedge clk);
    hilo_wr = 1'b0; start = 1'b0;
    check_eq("run_hi_hold", 64'(hi), 64'hDEADBEEF);
    check_eq("run_lo_hold", 64'(lo), 64'h0BADF00D);
    wait_done(lat, bcnt);
    check_eq("run_lat_remaining", 64'(lat), 64'd27);
    check_eq("run_res_lo", 64'(lo), 64'd42);
    check_eq("run_res_hi", 64'(hi), 64'd0);

    // Back-to-back: start in the done cycle.
    op_check("b2b_divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Write and start together: write lands, then the result overwrites it.
    hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1111;
    launch(2'b00, 32'd2, 32'd3);
    hilo_wr = 1'b0;
    check_eq("wr_start_hi_written", 64'(hi), 64'h1111);
    wait_done(lat, bcnt);
    check_eq("wr_start_hi", 64'(hi), 64'd0);
    check_eq("wr_start_lo", 64'(lo), 64'd6);
    @(negedge clk);

    // Reset mid-RUN aborts with no done.
    launch(2'b00, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    op_check("after_abort_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
